// File: rtl/ps2_scan_receiver_if.sv
// Scan-code output bundle of the PS/2 receiver: published code, ready strobe,
// digit flag and framing-error strobe.
interface ps2_scan_receiver_if;
    logic [7:0] scan;
    logic       ready;
    logic       is_number;
    logic       frame_err;

    modport master (output scan, output ready, output is_number, output frame_err);
    modport slave  (input  scan, input  ready, input  is_number, input  frame_err);
endinterface

// File: rtl/ps2_scan_receiver.sv
// PS/2 keyboard receiver: synchronises, deframes, checks parity and publishes released scan codes.
// Optional ps2clk glitch filter enabled by defining PS2_GLITCH_FILTER_EN.
module ps2_scan_receiver #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned FILTER_LEN     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ps2clk,
    input  logic                 ps2data,
    ps2_scan_receiver_if.master  out_if
);
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if (FILTER_LEN < 2) begin : g_bad_filter
        $error("FILTER_LEN must be at least 2");
    end

    typedef enum logic [1:0] {IDLE, RECV, DONE} state_e;

    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
    logic                   clk_s, data_s;
    logic                   clk_prev_q, clk_prev_d;
    logic                   fall_c;

    state_e                 state_q, state_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic                   par_q, par_d;
    logic                   stop_q, stop_d;
    logic                   brk_q, brk_d;
    logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
    logic [7:0]             scan_q, scan_d;
    logic                   ready_q, ready_d;
    logic                   num_q, num_d;
    logic                   err_q, err_d;

    assign clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ps2clk};
    assign data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ps2data};

`ifdef PS2_GLITCH_FILTER_EN
    localparam int unsigned FL_W = $clog2(FILTER_LEN) + 1;

    logic [FL_W-1:0]       flt_cnt_q, flt_cnt_d;
    logic                  flt_lvl_q, flt_lvl_d;
    logic [FILTER_LEN-1:0] data_dly_q, data_dly_d;

    // Saturating filter; data is delayed by the same depth so each fall still samples its own bit.
    always_comb begin
        flt_cnt_d  = flt_cnt_q;
        flt_lvl_d  = flt_lvl_q;
        data_dly_d = {data_dly_q[FILTER_LEN-2:0], data_sync_q[SYNC_STAGES-1]};
        if (clk_sync_q[SYNC_STAGES-1] == flt_lvl_q) begin
            flt_cnt_d = '0;
        end else if (flt_cnt_q == FL_W'(FILTER_LEN - 1)) begin
            flt_lvl_d = clk_sync_q[SYNC_STAGES-1];
            flt_cnt_d = '0;
        end else begin
            flt_cnt_d = flt_cnt_q + FL_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flt_cnt_q  <= '0;
            flt_lvl_q  <= 1'b1;
            data_dly_q <= '1;
        end else begin
            flt_cnt_q  <= flt_cnt_d;
            flt_lvl_q  <= flt_lvl_d;
            data_dly_q <= data_dly_d;
        end
    end

    assign clk_s  = flt_lvl_q;
    assign data_s = data_dly_q[FILTER_LEN-1];
`else
    assign clk_s  = clk_sync_q[SYNC_STAGES-1];
    assign data_s = data_sync_q[SYNC_STAGES-1];
`endif

    assign clk_prev_d = clk_s;
    assign fall_c     = clk_prev_q & ~clk_s;

    function automatic logic is_digit(input logic [7:0] code);
        case (code)
            8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
            8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46: is_digit = 1'b1;
            default:                           is_digit = 1'b0;
        endcase
    endfunction

    // Frame FSM and make/break tracking
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        stop_d    = stop_q;
        brk_d     = brk_q;
        to_cnt_d  = to_cnt_q;
        scan_d    = scan_q;
        num_d     = num_q;
        ready_d   = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (fall_c) begin
                    if (!data_s) begin
                        state_d   = RECV;
                        bit_cnt_d = '0;
                        to_cnt_d  = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RECV: begin
                if (fall_c) begin
                    to_cnt_d  = '0;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q < 4'd8) begin
                        shift_d = {data_s, shift_q[7:1]};
                    end else if (bit_cnt_q == 4'd8) begin
                        par_d = data_s;
                    end else begin
                        stop_d  = data_s;
                        state_d = DONE;
                    end
                end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            DONE: begin
                state_d   = IDLE;
                bit_cnt_d = '0;
                if ((^{shift_q, par_q}) && stop_q) begin
                    if (shift_q == 8'hF0) begin
                        brk_d = 1'b1;
                    end else if (shift_q == 8'hE0) begin
                        brk_d = brk_q;
                    end else if (brk_q) begin
                        scan_d  = shift_q;
                        num_d   = is_digit(shift_q);
                        ready_d = 1'b1;
                        brk_d   = 1'b0;
                    end
                end else begin
                    err_d = 1'b1;
                    brk_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            clk_prev_q  <= 1'b1;
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            stop_q      <= 1'b0;
            brk_q       <= 1'b0;
            to_cnt_q    <= '0;
            scan_q      <= '0;
            ready_q     <= 1'b0;
            num_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            clk_prev_q  <= clk_prev_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            stop_q      <= stop_d;
            brk_q       <= brk_d;
            to_cnt_q    <= to_cnt_d;
            scan_q      <= scan_d;
            ready_q     <= ready_d;
            num_q       <= num_d;
            err_q       <= err_d;
        end
    end

    assign out_if.scan      = scan_q;
    assign out_if.ready     = ready_q;
    assign out_if.is_number = num_q;
    assign out_if.frame_err = err_q;
endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Scoreboard bench for ps2_scan_receiver: frame-level key model feeds an expected-event queue.
module tb_ps2_scan_receiver;
    localparam int unsigned SYNC = 2;
    localparam int unsigned TMO  = 200;
    localparam int unsigned FLEN = 4;
    localparam int unsigned HALF = 10;
`ifdef PS2_GLITCH_FILTER_EN
    localparam int LAT = int'(SYNC + 2 + FLEN);
`else
    localparam int LAT = int'(SYNC + 2);
`endif

    logic clk = 1'b0;
    logic reset;
    logic ps2clk;
    logic ps2data;

    ps2_scan_receiver_if bus ();

    ps2_scan_receiver #(
        .SYNC_STAGES    (SYNC),
        .TIMEOUT_CYCLES (TMO),
        .FILTER_LEN     (FLEN)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .ps2clk  (ps2clk),
        .ps2data (ps2data),
        .out_if  (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        bit         is_err;
        logic [7:0] code;
        bit         num;
    } ev_t;

    ev_t        exp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] held_scan = 8'h00;
    bit         held_num  = 1'b0;
    bit         model_brk = 1'b0;
    int         stop_cyc  = 0;

    function automatic void check(input bit ok, input string name, input longint act, input longint exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic bit digit_ref(input logic [7:0] b);
        logic [7:0] digits [10];
        digits = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
        foreach (digits[i]) if (digits[i] == b) return 1'b1;
        return 1'b0;
    endfunction

    // Key-level behaviour: what one received frame should produce
    function automatic void model_frame(input logic [7:0] b, input bit good);
        if (!good) begin
            exp_q.push_back('{is_err: 1'b1, code: 8'h00, num: 1'b0});
            model_brk = 1'b0;
        end else if (b == 8'hF0) begin
            model_brk = 1'b1;
        end else if (b == 8'hE0) begin
            model_brk = model_brk;
        end else if (model_brk) begin
            exp_q.push_back('{is_err: 1'b0, code: b, num: digit_ref(b)});
            model_brk = 1'b0;
        end
    endfunction

    function automatic void push_err();
        exp_q.push_back('{is_err: 1'b1, code: 8'h00, num: 1'b0});
    endfunction

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits, input int glitch_k);
        logic [10:0] bits;
        bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int k = 0; k < nbits; k++) begin
            @(negedge clk);
            ps2data = bits[k];
            if (k == glitch_k) begin
                repeat (4) @(negedge clk);
                ps2clk = 1'b0;
                repeat (2) @(negedge clk);
                ps2clk = 1'b1;
                repeat (HALF - 6) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            ps2clk = 1'b0;
            if (k == 10) stop_cyc = cyc;
            repeat (HALF) @(negedge clk);
            ps2clk = 1'b1;
        end
        ps2data = 1'b1;
        repeat (30) @(negedge clk);
    endtask

    task automatic key(input logic [7:0] b);
        model_frame(b, 1'b1);
        send_frame(b, 1'b0, 11, -1);
    endtask

    task automatic bad_key(input logic [7:0] b);
        model_frame(b, 1'b0);
        send_frame(b, 1'b1, 11, -1);
    endtask

    // Monitor: pops the scoreboard whenever the DUT strobes, otherwise checks the outputs hold
    always @(negedge clk) begin
        if (!reset) begin
            check(!(bus.ready && bus.frame_err), "ready_err_overlap", {bus.ready, bus.frame_err}, 0);
            if (bus.ready) begin
                if (exp_q.size() == 0 || exp_q[0].is_err) begin
                    check(1'b0, "unexpected_ready", bus.scan, 0);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    check(bus.scan == e.code, "scan", bus.scan, e.code);
                    check(bus.is_number == e.num, "is_number", bus.is_number, e.num);
                    check(cyc - stop_cyc == LAT, "ready_latency", cyc - stop_cyc, LAT);
                    held_scan = e.code;
                    held_num  = e.num;
                end
            end else if (bus.frame_err) begin
                if (exp_q.size() == 0 || !exp_q[0].is_err) begin
                    check(1'b0, "unexpected_frame_err", bus.frame_err, 0);
                end else begin
                    void'(exp_q.pop_front());
                    check(1'b1, "frame_err", 1, 1);
                end
            end else begin
                check(bus.scan == held_scan, "scan_held", bus.scan, held_scan);
                check(bus.is_number == held_num, "is_number_held", bus.is_number, held_num);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check(bus.scan == 8'h00, {tag, "_scan"}, bus.scan, 0);
        check(bus.ready == 1'b0, {tag, "_ready"}, bus.ready, 0);
        check(bus.is_number == 1'b0, {tag, "_is_number"}, bus.is_number, 0);
        check(bus.frame_err == 1'b0, {tag, "_frame_err"}, bus.frame_err, 0);
    endtask

    initial begin
        reset   = 1'b1;
        ps2clk  = 1'b1;
        ps2data = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        reset = 1'b0;
        repeat (10) @(negedge clk);

        // Digit '5' then '+'
        key(8'h2E); key(8'hF0); key(8'h2E);
        key(8'h79); key(8'hF0); key(8'h79);
        // Extended Enter
        key(8'hE0); key(8'h5A); key(8'hE0); key(8'hF0); key(8'h5A);
        // Corrupted break prefix, then a clean release
        bad_key(8'hF0); key(8'h16);
        key(8'hF0); key(8'h16);

        // Timeout mid-frame keeps a pending break
        key(8'hF0);
        push_err();
        send_frame(8'h55, 1'b0, 5, -1);
        repeat (TMO + 50) @(negedge clk);
        key(8'h1E);

        // Reset mid-frame
        send_frame(8'h33, 1'b0, 4, -1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check_reset_outputs("mid_reset");
        held_scan = 8'h00;
        held_num  = 1'b0;
        model_brk = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        key(8'hF0); key(8'h45);

        // Glitch on ps2clk inside an F0 frame
`ifdef PS2_GLITCH_FILTER_EN
        model_frame(8'hF0, 1'b1);
        send_frame(8'hF0, 1'b0, 11, 1);
        key(8'h26);
`else
        push_err();
        push_err();
        model_brk = 1'b0;
        send_frame(8'hF0, 1'b0, 11, 1);
        key(8'h26);
`endif

        // Randomised key sessions
        for (int n = 0; n < 25; n++) begin
            logic [7:0] c;
            bit         ext;
            if ($urandom_range(0, 2) == 0) c = 8'h16 + 8'($urandom_range(0, 1) * 8);
            else if ($urandom_range(0, 1) == 0) c = 8'h45;
            else c = 8'($urandom_range(1, 127));
            ext = ($urandom_range(0, 3) == 0);
            if (ext) key(8'hE0);
            key(c);
            for (int r = int'($urandom_range(0, 2)); r > 0; r--) key(c);
            if (ext) key(8'hE0);
            key(8'hF0);
            if ($urandom_range(0, 6) == 0) bad_key(c);
            else key(c);
        end

        repeat (50) @(negedge clk);
        check(exp_q.size() == 0, "pending_events", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
